// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the data-cache memory port.
// Accepts one word or byte read/write at a time, waits LATENCY cycles to
// model DRAM latency, performs the access on an internal word array and
// pulses `ready` for one cycle.
//
// Parameters:
//   MEM_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY    cycles from acceptance edge to the ready pulse (1..255)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  request present (sampled only in IDLE)
//   req_write  1 = write, 0 = read
//   req_byte   1 = single-byte access, 0 = full word
//   req_addr   byte address; upper bits beyond the array wrap
//   req_wdata  write data, lane 0 = MSB ({lane0,lane1,lane2,lane3})
//   rdata      read data, same lane order; holds until the next read
//   ready      one-cycle completion pulse
//   busy       request in flight
//   err        misaligned word access flag (only with MEM_RESP_ALIGN_CHECK_EN)
//
// Build option: define MEM_RESP_ALIGN_CHECK_EN to reject word accesses
// whose addr[1:0] != 0 (no write, no rdata update, err with ready).
// Without it addr[1:0] is ignored for word accesses.

module mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic            req_byte,
  input  logic [31:0]     req_addr,
  input  logic [0:3][7:0] req_wdata,
  output logic [0:3][7:0] rdata,
  output logic            ready,
  output logic            busy
`ifdef MEM_RESP_ALIGN_CHECK_EN
  ,
  output logic            err
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [7:0]      cnt, cnt_nx;
  logic            cap;      // latch the request this edge
  logic            acc;      // this edge enters RESP: perform the access

  // captured request (only the address bits that index the array)
  logic            wr_q, byte_q;
  logic [AW+1:0]   addr_q;
  logic [0:3][7:0] wdata_q;

  logic [0:3][7:0] mem [MEM_WORDS];

  // Access fields: with LATENCY == 1 the access happens on the acceptance
  // edge itself, so the live request is used instead of the captured copy.
  logic            a_write, a_byte, a_bad, mem_we, rd_upd;
  logic [AW+1:0]   a_addr;
  logic [0:3][7:0] a_wdata;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign a_write = (state == IDLE) ? req_write           : wr_q;
  assign a_byte  = (state == IDLE) ? req_byte            : byte_q;
  assign a_addr  = (state == IDLE) ? req_addr[AW+1:0]    : addr_q;
  assign a_wdata = (state == IDLE) ? req_wdata           : wdata_q;
  assign idx     = a_addr[AW+1:2];
  assign lane    = a_addr[1:0];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign a_bad = !a_byte && (a_addr[1:0] != 2'b00);
`else
  assign a_bad = 1'b0;
`endif

  // reset gates the write so an access whose RESP entry never happened
  // cannot touch the array while reset is held
  assign mem_we = acc && a_write && !a_bad && !reset;
  assign rd_upd = acc && !a_write && !a_bad;

  // ready is registered off RESP, so it trails RESP by one cycle; busy is
  // stretched over that cycle so it covers the whole transaction.
  assign busy = (state != IDLE) || ready;

  // next-state / control
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    acc      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cap    = 1'b1;
          cnt_nx = LAT_M1;
          if (LATENCY == 1) begin
            state_nx = RESP;
            acc      = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) begin
          state_nx = RESP;
          acc      = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ready <= (state == RESP);
      if (cap) begin
        wr_q    <= req_write;
        byte_q  <= req_byte;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
      end
      if (rd_upd) begin
        if (a_byte) rdata <= {8'h00, 8'h00, 8'h00, mem[idx][lane]};
        else        rdata <= mem[idx];
      end
    end
  end

`ifdef MEM_RESP_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= (state == RESP) && !byte_q && (addr_q[1:0] != 2'b00);
  end
`endif

  // word array: no reset, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (a_byte) mem[idx][lane] <= a_wdata[3];
      else        mem[idx]       <= a_wdata;
    end
  end

endmodule
